// File: rtl/bus_mux_reg.sv
// Registered, parametrised shared-bus multiplexer with a valid flag, hold-on-idle and
// illegal (multi-hot) select detection with a sticky flag and a saturating counter.
module bus_mux_reg #(
    parameter int WIDTH        = 16,
    parameter int NREG         = 8,
    parameter bit HOLD_ON_IDLE = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NREG-1:0]       Rout,
    input  logic                  Gout,
    input  logic                  DINout,
    input  logic [NREG*WIDTH-1:0] Q,
    input  logic [WIDTH-1:0]      G,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  ErrClr,
    output logic [WIDTH-1:0]      BUSWIRE,
    output logic                  BusValid,
    output logic                  SelErr,
    output logic [CNT_W-1:0]      ErrCount
);

    localparam int              SELW    = NREG + 2;
    localparam logic [SELW-1:0] SEL_ONE = SELW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SELW-1:0]  w_sel;
    logic             w_idle;
    logic             w_one_hot;
    logic             w_multi;
    logic [WIDTH-1:0] w_src;

    logic [WIDTH-1:0] r_bus;
    logic             r_valid;
    logic             r_sel_err;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_sel     = {Rout, Gout, DINout};
    assign w_idle    = (w_sel == '0);
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign w_one_hot = !w_idle && ((w_sel & (w_sel - SEL_ONE)) == '0);
    assign w_multi   = !w_idle && !w_one_hot;

    // AND-OR source mux; only consumed when the select is one-hot, so no priority needed.
    always_comb begin
        // NOTE: defaulting every combinational output first keeps this block latch-free.
        w_src = '0;
        w_src = w_src | ({WIDTH{DINout}} & DIN);
        w_src = w_src | ({WIDTH{Gout}} & G);
        for (int i = 0; i < NREG; i++) begin
            w_src = w_src | ({WIDTH{Rout[i]}} & Q[i*WIDTH +: WIDTH]);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_bus     <= '0;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_one_hot) begin
                r_bus   <= w_src;
                r_valid <= 1'b1;
            end else if (w_idle) begin
                r_valid <= 1'b0;
                if (!HOLD_ON_IDLE) begin
                    r_bus <= '0;
                end
            end else begin
                r_valid <= 1'b0;
            end

            // A fresh error in the same cycle as a clear restarts the count at one.
            if (w_multi) begin
                r_sel_err <= 1'b1;
                if (ErrClr) begin
                    r_err_cnt <= CNT_W'(1);
                end else if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end else if (ErrClr) begin
                r_sel_err <= 1'b0;
                r_err_cnt <= '0;
            end
        end
    end

    assign BUSWIRE  = r_bus;
    assign BusValid = r_valid;
    assign SelErr   = r_sel_err;
    assign ErrCount = r_err_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg: a default build and a 32-bit/4-register/clear-on-idle
// build share one stimulus stream, each checked every cycle against its own behavioural model.
module tb_bus_mux_reg;

    localparam int  W1 = 16, N1 = 8, C1 = 8;
    localparam bit  H1 = 1'b1;
    localparam int  W2 = 32, N2 = 4, C2 = 4;
    localparam bit  H2 = 1'b0;

    logic clk;
    logic rst;
    logic [7:0] rout;
    logic gout, dinout, errclr;

    logic [N1-1:0][W1-1:0] q1;
    logic [W1-1:0]         g1, din1;
    logic [W1-1:0]         bus1;
    logic                  valid1, selerr1;
    logic [C1-1:0]         cnt1;

    logic [N2-1:0][W2-1:0] q2;
    logic [W2-1:0]         g2, din2;
    logic [W2-1:0]         bus2;
    logic                  valid2, selerr2;
    logic [C2-1:0]         cnt2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [W1-1:0] m_bus1;
    logic          m_v1, m_e1;
    int            m_c1;
    logic [W2-1:0] m_bus2;
    logic          m_v2, m_e2;
    int            m_c2;
    int            n1, n2;

    bus_mux_reg #(.WIDTH(W1), .NREG(N1), .HOLD_ON_IDLE(H1), .CNT_W(C1)) u_dut1 (
        .Clock(clk), .Reset(rst), .Rout(rout), .Gout(gout), .DINout(dinout),
        .Q(q1), .G(g1), .DIN(din1), .ErrClr(errclr),
        .BUSWIRE(bus1), .BusValid(valid1), .SelErr(selerr1), .ErrCount(cnt1)
    );

    bus_mux_reg #(.WIDTH(W2), .NREG(N2), .HOLD_ON_IDLE(H2), .CNT_W(C2)) u_dut2 (
        .Clock(clk), .Reset(rst), .Rout(rout[N2-1:0]), .Gout(gout), .DINout(dinout),
        .Q(q2), .G(g2), .DIN(din2), .ErrClr(errclr),
        .BUSWIRE(bus2), .BusValid(valid2), .SelErr(selerr2), .ErrCount(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The second build sees derived data so its 32-bit paths carry distinct upper halves.
    always_comb begin
        for (int i = 0; i < N2; i++) q2[i] = {16'hC0DE, q1[i]};
        q2[3] = 32'hDEADBEEF;
        g2    = {g1, ~g1};
        din2  = {din1, din1};
    end

    assign n1 = $countones({rout, gout, dinout});
    assign n2 = $countones({rout[N2-1:0], gout, dinout});

    function automatic logic [W1-1:0] pick1();
        if (dinout) return din1;
        if (gout)   return g1;
        for (int i = 0; i < N1; i++) if (rout[i]) return q1[i];
        return '0;
    endfunction

    function automatic logic [W2-1:0] pick2();
        if (dinout) return din2;
        if (gout)   return g2;
        for (int i = 0; i < N2; i++) if (rout[i]) return q2[i];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_bus1 <= '0; m_v1 <= 1'b0; m_e1 <= 1'b0; m_c1 <= 0;
        end else if (n1 >= 2) begin
            m_v1 <= 1'b0;
            m_e1 <= 1'b1;
            m_c1 <= errclr ? 1 : ((m_c1 == (1 << C1) - 1) ? m_c1 : m_c1 + 1);
        end else begin
            m_v1 <= (n1 == 1);
            if (n1 == 1)  m_bus1 <= pick1();
            else if (!H1) m_bus1 <= '0;
            if (errclr) begin m_e1 <= 1'b0; m_c1 <= 0; end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_bus2 <= '0; m_v2 <= 1'b0; m_e2 <= 1'b0; m_c2 <= 0;
        end else if (n2 >= 2) begin
            m_v2 <= 1'b0;
            m_e2 <= 1'b1;
            m_c2 <= errclr ? 1 : ((m_c2 == (1 << C2) - 1) ? m_c2 : m_c2 + 1);
        end else begin
            m_v2 <= (n2 == 1);
            if (n2 == 1)  m_bus2 <= pick2();
            else if (!H2) m_bus2 <= '0;
            if (errclr) begin m_e2 <= 1'b0; m_c2 <= 0; end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("bus1",    64'(bus1),    64'(m_bus1));
            check("valid1",  64'(valid1),  64'(m_v1));
            check("selerr1", 64'(selerr1), 64'(m_e1));
            check("cnt1",    64'(cnt1),    64'(m_c1));
            check("bus2",    64'(bus2),    64'(m_bus2));
            check("valid2",  64'(valid2),  64'(m_v2));
            check("selerr2", 64'(selerr2), 64'(m_e2));
            check("cnt2",    64'(cnt2),    64'(m_c2));
        end
    end

    // Apply one select pattern and advance to the next sampling point.
    task automatic step(input logic [7:0] r, input logic g, input logic d, input logic c);
        rout = r; gout = g; dinout = d; errclr = c;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rout = '0; gout = 1'b0; dinout = 1'b1; errclr = 1'b0;
        q1 = '0; g1 = '0; din1 = 16'hFFFF;

        // Reset held two cycles while DIN is selected
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_bus",    64'(bus1),     64'h0);
        check("rst_valid",  64'(valid1),   64'h0);
        check("rst_selerr", 64'(selerr1),  64'h0);
        check("rst_cnt",    64'(cnt1),     64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_bus",   64'(bus1),   64'hFFFF);
        check("post_rst_valid", 64'(valid1), 64'h1);
        check("post_rst_bus2",  64'(bus2),   64'hFFFF_FFFF);

        // Sweep of every legal one-hot select
        for (int i = 0; i < N1; i++) q1[i] = 16'h1000 + 16'(i);
        g1 = 16'hA5A5; din1 = 16'h5A5A;
        for (int i = 0; i < N1; i++) begin
            step(8'(1 << i), 1'b0, 1'b0, 1'b0);
            check("sweep_bus", 64'(bus1), 64'h1000 + 64'(i));
            check("sweep_valid", 64'(valid1), 64'h1);
            if (i == 3) check("sweep_bus2_q3", 64'(bus2), 64'hDEAD_BEEF);
        end
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("sweep_g", 64'(bus1), 64'hA5A5);
        check("sweep_g2", 64'(bus2), 64'hA5A5_5A5A);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("sweep_din", 64'(bus1), 64'h5A5A);

        // Idle: hold in the default build, clear in the second
        din1 = 16'h1234;
        step(8'h00, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        check("idle_bus",   64'(bus1),   64'h1234);
        check("idle_valid", 64'(valid1), 64'h0);
        check("idle_bus2",  64'(bus2),   64'h0);

        // Multi-hot holds the bus and counts, saturating
        q1[0] = 16'h00C3;
        step(8'h01, 1'b0, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0, 1'b0);
        check("multi_bus",    64'(bus1),    64'h00C3);
        check("multi_valid",  64'(valid1),  64'h0);
        check("multi_selerr", 64'(selerr1), 64'h1);
        check("multi_cnt",    64'(cnt1),    64'h1);
        for (int i = 0; i < 299; i++) step(8'h03, 1'b0, 1'b0, 1'b0);
        check("sat_cnt",  64'(cnt1), 64'd255);
        check("sat_cnt2", 64'(cnt2), 64'd15);

        // ErrClr alone, and ErrClr colliding with a new error
        step(8'h03, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(8'h03, 1'b0, 1'b0, 1'b0);
        check("cnt_five", 64'(cnt1), 64'd5);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_selerr", 64'(selerr1), 64'h0);
        check("clr_cnt",    64'(cnt1),    64'h0);
        check("clr_bus",    64'(bus1),    64'h00C3);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        check("clr_err_selerr", 64'(selerr1), 64'h1);
        check("clr_err_cnt",    64'(cnt1),    64'h1);
        step(8'h00, 1'b1, 1'b0, 1'b1);
        check("clr_legal_bus",   64'(bus1),    64'hA5A5);
        check("clr_legal_valid", 64'(valid1),  64'h1);
        check("clr_legal_err",   64'(selerr1), 64'h0);

        // Mid-stream reset, then a normal load
        step(8'h03, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(8'h04, 1'b0, 1'b0, 1'b0);
        check("mid_rst_bus",    64'(bus1),    64'h0);
        check("mid_rst_selerr", 64'(selerr1), 64'h0);
        rst = 1'b0;
        step(8'h04, 1'b0, 1'b0, 1'b0);
        check("after_rst_bus",   64'(bus1),   64'h1002);
        check("after_rst_valid", 64'(valid1), 64'h1);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
